jstk_frame_ctrl: RTL and testbench
==================================

# jstk_frame_ctrl

Frame-level controller sitting directly above the SPI mode 0 byte engine in the PmodJSTK path. On a sample request it holds slave select low and commands five consecutive byte reads from the byte engine. It collects the five raw bytes and publishes a decoded joystick frame atomically: 10-bit X, 10-bit Y and 3 button bits. It also detects a stalled byte engine and aborts with an error flag.

## Interface
- `TMO_START`, default 4: cycles allowed for the engine's `BUSY` to rise after a byte request.
- `TMO_XFER`, default 24: cycles allowed for `BUSY` to fall once it has risen.
- `CLK`  in  1  serial-rate clock (66.67 kHz, same clock as the byte engine); all logic on rising edge.
- `RST`  in  1  synchronous, active-high reset.
- `sndRec`  in  1  frame request; sampled only in IDLE.
- `byteBusy`  in  1  `BUSY` from the byte engine.
- `byteIn`  in  8  `DOUT` from the byte engine.
- `getByte`  out  1  drives the byte engine's `sndRec`.
- `SS`  out  1  slave select to PmodJSTK, active low.
- `BUSY`  out  1  high from request acceptance until return to IDLE.
- `DONE`  out  1  one-cycle pulse when a valid frame is published.
- `ERR`  out  1  one-cycle pulse on timeout abort.
- `posX`  out  10  X position.
- `posY`  out  10  Y position.
- `btn`  out  3  button bits {BTN2, BTN1, BTN0}.

## Operation
- States: IDLE, SETUP, REQ, XFER, GAP, PUBLISH, ABORT.
- IDLE: `SS`=1, `getByte`=0, `BUSY`=0, byte index `idx`=0. If `sndRec`=1, go to SETUP.
- SETUP, 1 cycle: `SS`=0, `BUSY`=1. This gives the slave at least 15 µs setup before the first SCLK. Go to REQ.
- REQ: `getByte`=1, timeout counter running.
  - When `byteBusy`=1 is sampled, drop `getByte` on the same edge and go to XFER.
  - If the counter reaches `TMO_START` first, go to ABORT.
- XFER: `getByte`=0, counter restarted.
  - When `byteBusy`=0 is sampled, write `byteIn` into raw byte `idx` and go to GAP.
  - If the counter reaches `TMO_XFER` first, go to ABORT.
- GAP, 1 cycle: enforces the ≥10 µs inter-byte gap.
  - If `idx`=4, go to PUBLISH.
  - Otherwise increment `idx` and go to REQ.
- PUBLISH, 1 cycle, decodes the raw bytes:
  - `posX` = {raw1[1:0], raw0}
  - `posY` = {raw3[1:0], raw2}
  - `btn` = raw4[2:0]
  - Pulse `DONE`=1, set `SS`=1, go to IDLE.
- ABORT, 1 cycle: `SS`=1, `getByte`=0, pulse `ERR`=1, go to IDLE. Published outputs are not modified.
- `getByte` must never be high while the FSM is in XFER. This keeps the engine, which re-triggers from its Idle state on `sndRec`=1, from starting a sixth byte.
- `sndRec` is ignored outside IDLE. If `sndRec` is held high, a new frame starts in the first IDLE cycle after PUBLISH or ABORT.
- Raw bytes 1, 3 and 4 have their unused high bits discarded.

## Timing
- Reset values:
  - `SS`=1
  - `getByte`=0
  - `BUSY`=0
  - `DONE`=0
  - `ERR`=0
  - `posX`=0
  - `posY`=0
  - `btn`=0
  - `idx`=0
  - raw bytes = 0
  - state = IDLE
- Reset asserted mid-frame: on the next edge `SS`=1 and `getByte`=0, no `DONE` and no `ERR`; published outputs return to 0.
- `sndRec` sampled high at edge n gives `SS`=0 and `BUSY`=1 after edge n+1. `getByte`=1 follows after edge n+2.
- Per-byte cost with the standard engine (Idle, Init, 9× RxTx, Done) is roughly 14 cycles. A full frame takes about 70–75 cycles, about 1.1 ms.
- `posX`, `posY` and `btn` change only on the PUBLISH edge, all together, coincident with `DONE` going high.
- `DONE` and `ERR` are never high in the same cycle; each is exactly 1 cycle wide.
- Both timeout counters are 5 bits and saturate. Their compares use ≥.

## Test plan
- Reset: hold `RST` for 3 cycles mid-frame → `SS`=1, `getByte`=0, all outputs 0, FSM idle; the following `sndRec` starts a clean frame.
- Nominal frame: engine model returns 0xA5, 0x02, 0x3C, 0x01, 0x05 → one `DONE` pulse with `posX`=0x2A5, `posY`=0x13C, `btn`=3'b101. `SS` stays low continuously across all 5 bytes, and exactly 5 `getByte` rising edges are seen.
- High-bit masking: bytes 0xFF, 0xFF, 0x00, 0xFE, 0xFF → `posX`=0x3FF, `posY`=0x200, `btn`=3'b111.
- Start timeout: engine never raises `byteBusy` → `ERR` pulses 4 cycles after `getByte` rises, `SS`=1, previous `posX`/`posY`/`btn` unchanged, no `DONE`.
- Transfer timeout: `byteBusy` stuck high during byte 2 → `ERR` after 24 cycles, `SS`=1, outputs unchanged.
- Request handling: `sndRec` pulsed during a frame is ignored (only one `DONE`). `sndRec` held high gives back-to-back frames, with exactly 1 IDLE cycle and `SS`=1 between them.

Source files
------------

// File: rtl/jstk_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : jstk_frame_ctrl
// Brief    : PmodJSTK frame sequencer. Reads five bytes through the SPI byte
//            engine, publishes X/Y/buttons atomically, aborts on engine stall.
// Revision : 1.0 - initial release
// ============================================================================
module jstk_frame_ctrl #(
    parameter int TMO_START = 4,
    parameter int TMO_XFER  = 24
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       sndRec,
    input  logic       byteBusy,
    input  logic [7:0] byteIn,
    output logic       getByte,
    output logic       SS,
    output logic       BUSY,
    output logic       DONE,
    output logic       ERR,
    output logic [9:0] posX,
    output logic [9:0] posY,
    output logic [2:0] btn
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SETUP   = 3'd1,
        S_REQ     = 3'd2,
        S_XFER    = 3'd3,
        S_GAP     = 3'd4,
        S_PUBLISH = 3'd5,
        S_ABORT   = 3'd6
    } state_t;

    localparam logic [4:0] c_TMO_START = 5'(TMO_START);
    localparam logic [4:0] c_TMO_XFER  = 5'(TMO_XFER);
    localparam logic [2:0] c_LAST_IDX  = 3'd4;

    state_t     state_q,    state_d;
    logic [2:0] idx_q,      idx_d;
    logic [4:0] cnt_q,      cnt_d;
    logic [4:0] cnt_inc;
    logic [7:0] raw0_q,     raw0_d;
    logic [1:0] raw1_q,     raw1_d;
    logic [7:0] raw2_q,     raw2_d;
    logic [1:0] raw3_q,     raw3_d;
    logic [2:0] raw4_q,     raw4_d;
    logic       get_byte_q, get_byte_d;
    logic       ss_q,       ss_d;
    logic       busy_q,     busy_d;
    logic       done_q,     done_d;
    logic       err_q,      err_d;
    logic [9:0] pos_x_q,    pos_x_d;
    logic [9:0] pos_y_q,    pos_y_d;
    logic [2:0] btn_q,      btn_d;

    // Saturating so a stuck engine can never wrap the counter past the limit
    assign cnt_inc = (cnt_q == 5'h1f) ? cnt_q : cnt_q + 5'd1;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        raw0_d     = raw0_q;
        raw1_d     = raw1_q;
        raw2_d     = raw2_q;
        raw3_d     = raw3_q;
        raw4_d     = raw4_q;
        get_byte_d = get_byte_q;
        ss_d       = ss_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        pos_x_d    = pos_x_q;
        pos_y_d    = pos_y_q;
        btn_d      = btn_q;

        case (state_q)
            S_IDLE: begin
                ss_d       = 1'b1;
                get_byte_d = 1'b0;
                busy_d     = 1'b0;
                idx_d      = 3'd0;
                cnt_d      = 5'd0;
                if (sndRec) begin
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                ss_d    = 1'b0;
                busy_d  = 1'b1;
                cnt_d   = 5'd0;
                state_d = S_REQ;
            end
            S_REQ: begin
                cnt_d = cnt_inc;
                if (byteBusy) begin
                    // Drop the request on the same edge the engine goes busy
                    get_byte_d = 1'b0;
                    cnt_d      = 5'd0;
                    state_d    = S_XFER;
                end else if (cnt_inc >= c_TMO_START) begin
                    get_byte_d = 1'b0;
                    state_d    = S_ABORT;
                end else begin
                    get_byte_d = 1'b1;
                end
            end
            S_XFER: begin
                get_byte_d = 1'b0;
                cnt_d      = cnt_inc;
                if (!byteBusy) begin
                    case (idx_q)
                        3'd0:    raw0_d = byteIn;
                        3'd1:    raw1_d = byteIn[1:0];
                        3'd2:    raw2_d = byteIn;
                        3'd3:    raw3_d = byteIn[1:0];
                        default: raw4_d = byteIn[2:0];
                    endcase
                    state_d = S_GAP;
                end else if (cnt_inc >= c_TMO_XFER) begin
                    state_d = S_ABORT;
                end
            end
            S_GAP: begin
                cnt_d = 5'd0;
                if (idx_q == c_LAST_IDX) begin
                    state_d = S_PUBLISH;
                end else begin
                    idx_d   = idx_q + 3'd1;
                    state_d = S_REQ;
                end
            end
            S_PUBLISH: begin
                pos_x_d = {raw1_q, raw0_q};
                pos_y_d = {raw3_q, raw2_q};
                btn_d   = raw4_q;
                done_d  = 1'b1;
                ss_d    = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            S_ABORT: begin
                ss_d       = 1'b1;
                get_byte_d = 1'b0;
                busy_d     = 1'b0;
                err_d      = 1'b1;
                state_d    = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= S_IDLE;
            idx_q      <= 3'd0;
            cnt_q      <= 5'd0;
            raw0_q     <= 8'd0;
            raw1_q     <= 2'd0;
            raw2_q     <= 8'd0;
            raw3_q     <= 2'd0;
            raw4_q     <= 3'd0;
            get_byte_q <= 1'b0;
            ss_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            pos_x_q    <= 10'd0;
            pos_y_q    <= 10'd0;
            btn_q      <= 3'd0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            raw0_q     <= raw0_d;
            raw1_q     <= raw1_d;
            raw2_q     <= raw2_d;
            raw3_q     <= raw3_d;
            raw4_q     <= raw4_d;
            get_byte_q <= get_byte_d;
            ss_q       <= ss_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            pos_x_q    <= pos_x_d;
            pos_y_q    <= pos_y_d;
            btn_q      <= btn_d;
        end
    end

    assign getByte = get_byte_q;
    assign SS      = ss_q;
    assign BUSY    = busy_q;
    assign DONE    = done_q;
    assign ERR     = err_q;
    assign posX    = pos_x_q;
    assign posY    = pos_y_q;
    assign btn     = btn_q;

endmodule
`default_nettype wire

// File: tb/tb_jstk_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_jstk_frame_ctrl
// Brief    : Directed bench for jstk_frame_ctrl with a behavioural byte engine.
// Revision : 1.0 - initial release
// ============================================================================
module tb_jstk_frame_ctrl;

    localparam int ENG_LEN = 10;

    logic       CLK      = 1'b0;
    logic       RST      = 1'b1;
    logic       sndRec   = 1'b0;
    logic       byteBusy = 1'b0;
    logic [7:0] byteIn   = 8'd0;
    logic       getByte;
    logic       SS;
    logic       BUSY;
    logic       DONE;
    logic       ERR;
    logic [9:0] posX;
    logic [9:0] posY;
    logic [2:0] btn;

    int checks = 0;
    int errors = 0;

    jstk_frame_ctrl #(
        .TMO_START (4),
        .TMO_XFER  (24)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .sndRec   (sndRec),
        .byteBusy (byteBusy),
        .byteIn   (byteIn),
        .getByte  (getByte),
        .SS       (SS),
        .BUSY     (BUSY),
        .DONE     (DONE),
        .ERR      (ERR),
        .posX     (posX),
        .posY     (posY),
        .btn      (btn)
    );

    always #5 CLK = ~CLK;

    // Byte engine model: busy for ENG_LEN cycles per request, data valid as busy falls
    logic [7:0] eng_bytes [5];
    int         eng_cnt   = 0;
    int         eng_bi    = 0;
    bit         eng_dead  = 1'b0;
    int         eng_stuck = -1;

    always @(negedge CLK) begin
        if (RST || SS) begin
            byteBusy = 1'b0;
            eng_cnt  = 0;
            eng_bi   = 0;
        end else if (eng_cnt == 0) begin
            if (getByte && !eng_dead) begin
                byteBusy = 1'b1;
                eng_cnt  = ENG_LEN;
            end
        end else if (eng_stuck != eng_bi) begin
            eng_cnt = eng_cnt - 1;
            if (eng_cnt == 0) begin
                byteBusy = 1'b0;
                byteIn   = eng_bytes[eng_bi];
                eng_bi   = eng_bi + 1;
            end
        end
    end

    int   gb_rises  = 0;
    int   ss_rises  = 0;
    int   n_done    = 0;
    int   n_err     = 0;
    int   n_overlap = 0;
    int   n_wide    = 0;
    logic gb_prev   = 1'b0;
    logic ss_prev   = 1'b1;
    logic done_prev = 1'b0;
    logic err_prev  = 1'b0;

    always @(posedge CLK) begin
        #2;
        if (getByte && !gb_prev) gb_rises++;
        if (SS && !ss_prev) ss_rises++;
        if (DONE) n_done++;
        if (ERR) n_err++;
        if (DONE && ERR) n_overlap++;
        if ((DONE && done_prev) || (ERR && err_prev)) n_wide++;
        gb_prev   = getByte;
        ss_prev   = SS;
        done_prev = DONE;
        err_prev  = ERR;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                        input logic [7:0] b3, input logic [7:0] b4);
        eng_bytes[0] = b0;
        eng_bytes[1] = b1;
        eng_bytes[2] = b2;
        eng_bytes[3] = b3;
        eng_bytes[4] = b4;
    endtask

    task automatic start_frame();
        sndRec = 1'b1;
        @(negedge CLK);
        sndRec = 1'b0;
    endtask

    task automatic wait_evt(input int maxc, output int cyc);
        cyc = 0;
        while (DONE !== 1'b1 && ERR !== 1'b1 && cyc < maxc) begin
            @(negedge CLK);
            cyc++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int s_gb;
        int s_ss;
        int s_done;
        int s_err;

        // Reset state
        load(8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        RST = 1'b1;
        repeat (3) @(negedge CLK);
        chk("rst_ss", SS, 1);
        chk("rst_getbyte", getByte, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_done", DONE, 0);
        chk("rst_err", ERR, 0);
        chk("rst_posx", posX, 0);
        chk("rst_posy", posY, 0);
        chk("rst_btn", btn, 0);
        RST = 1'b0;
        @(negedge CLK);

        // Nominal frame with request latency checks
        load(8'hA5, 8'h02, 8'h3C, 8'h01, 8'h05);
        s_gb = gb_rises; s_ss = ss_rises; s_done = n_done; s_err = n_err;
        start_frame();
        chk("lat_ss_edge_n", SS, 1);
        @(negedge CLK);
        chk("lat_ss_edge_n1", SS, 0);
        chk("lat_busy_edge_n1", BUSY, 1);
        chk("lat_gb_edge_n1", getByte, 0);
        @(negedge CLK);
        chk("lat_gb_edge_n2", getByte, 1);
        wait_evt(200, cyc);
        chk("nom_done", DONE, 1);
        chk("nom_no_err", n_err - s_err, 0);
        chk("nom_posx", posX, 10'h2A5);
        chk("nom_posy", posY, 10'h13C);
        chk("nom_btn", btn, 3'b101);
        chk("nom_ss_at_done", SS, 1);
        chk("nom_busy_at_done", BUSY, 0);
        chk("nom_gb_rises", gb_rises - s_gb, 5);
        chk("nom_ss_continuous", ss_rises - s_ss, 1);
        @(negedge CLK);
        chk("nom_done_width", DONE, 0);
        chk("nom_done_count", n_done - s_done, 1);

        // High-bit masking
        load(8'hFF, 8'hFF, 8'h00, 8'hFE, 8'hFF);
        start_frame();
        wait_evt(200, cyc);
        chk("mask_done", DONE, 1);
        chk("mask_posx", posX, 10'h3FF);
        chk("mask_posy", posY, 10'h200);
        chk("mask_btn", btn, 3'b111);
        @(negedge CLK);

        // Start timeout: engine never goes busy
        eng_dead = 1'b1;
        s_done = n_done;
        start_frame();
        cyc = 0;
        while (getByte !== 1'b1 && cyc < 10) begin
            @(negedge CLK);
            cyc++;
        end
        chk("stmo_req_seen", getByte, 1);
        cyc = 0;
        while (ERR !== 1'b1 && cyc < 40) begin
            @(negedge CLK);
            cyc++;
        end
        chk("stmo_latency", cyc, 4);
        chk("stmo_err", ERR, 1);
        chk("stmo_ss", SS, 1);
        chk("stmo_getbyte", getByte, 0);
        chk("stmo_posx_kept", posX, 10'h3FF);
        chk("stmo_posy_kept", posY, 10'h200);
        chk("stmo_btn_kept", btn, 3'b111);
        chk("stmo_no_done", n_done - s_done, 0);
        @(negedge CLK);
        chk("stmo_err_width", ERR, 0);
        chk("stmo_busy_idle", BUSY, 0);
        eng_dead = 1'b0;

        // Transfer timeout: busy stuck on the third byte (index 2)
        load(8'h11, 8'h01, 8'h22, 8'h02, 8'h03);
        eng_stuck = 2;
        s_gb = gb_rises; s_done = n_done;
        start_frame();
        cyc = 0;
        while ((gb_rises - s_gb) < 3 && cyc < 200) begin
            @(negedge CLK);
            cyc++;
        end
        chk("xtmo_third_req", gb_rises - s_gb, 3);
        cyc = 0;
        while (getByte !== 1'b0 && cyc < 10) begin
            @(negedge CLK);
            cyc++;
        end
        chk("xtmo_req_dropped", getByte, 0);
        cyc = 0;
        while (ERR !== 1'b1 && cyc < 60) begin
            @(negedge CLK);
            cyc++;
        end
        // 24 transfer cycles plus the abort cycle
        chk("xtmo_latency", cyc, 25);
        chk("xtmo_ss", SS, 1);
        chk("xtmo_posx_kept", posX, 10'h3FF);
        chk("xtmo_btn_kept", btn, 3'b111);
        chk("xtmo_no_done", n_done - s_done, 0);
        eng_stuck = -1;
        @(negedge CLK);

        // Reset in the middle of a frame
        load(8'h12, 8'h03, 8'h34, 8'h02, 8'h06);
        s_done = n_done; s_err = n_err;
        start_frame();
        repeat (20) @(negedge CLK);
        chk("mrst_in_frame", SS, 0);
        RST = 1'b1;
        @(negedge CLK);
        chk("mrst_ss", SS, 1);
        chk("mrst_getbyte", getByte, 0);
        chk("mrst_busy", BUSY, 0);
        chk("mrst_posx", posX, 0);
        chk("mrst_posy", posY, 0);
        chk("mrst_btn", btn, 0);
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        chk("mrst_no_done", n_done - s_done, 0);
        chk("mrst_no_err", n_err - s_err, 0);

        s_gb = gb_rises;
        start_frame();
        wait_evt(200, cyc);
        chk("post_rst_done", DONE, 1);
        chk("post_rst_posx", posX, 10'h312);
        chk("post_rst_posy", posY, 10'h234);
        chk("post_rst_btn", btn, 3'b110);
        chk("post_rst_gb_rises", gb_rises - s_gb, 5);
        @(negedge CLK);

        // Request pulse during a frame is ignored
        load(8'h5A, 8'h01, 8'hC3, 8'h02, 8'h03);
        s_done = n_done;
        start_frame();
        repeat (15) @(negedge CLK);
        sndRec = 1'b1;
        @(negedge CLK);
        sndRec = 1'b0;
        wait_evt(200, cyc);
        chk("ign_done", DONE, 1);
        chk("ign_posx", posX, 10'h15A);
        chk("ign_posy", posY, 10'h2C3);
        chk("ign_btn", btn, 3'b011);
        repeat (40) @(negedge CLK);
        chk("ign_single_done", n_done - s_done, 1);
        chk("ign_idle_busy", BUSY, 0);
        chk("ign_idle_ss", SS, 1);

        // Held request gives back-to-back frames
        load(8'h00, 8'h03, 8'hFF, 8'h00, 8'h02);
        s_done = n_done;
        sndRec = 1'b1;
        wait_evt(200, cyc);
        chk("b2b_first_done", DONE, 1);
        @(negedge CLK);
        chk("b2b_gap_ss", SS, 1);
        chk("b2b_gap_busy", BUSY, 0);
        chk("b2b_gap_done", DONE, 0);
        @(negedge CLK);
        chk("b2b_restart_ss", SS, 0);
        chk("b2b_restart_busy", BUSY, 1);
        sndRec = 1'b0;
        wait_evt(200, cyc);
        chk("b2b_second_done", DONE, 1);
        chk("b2b_done_count", n_done - s_done, 2);
        chk("b2b_posx", posX, 10'h300);
        chk("b2b_posy", posY, 10'h0FF);
        chk("b2b_btn", btn, 3'b010);
        repeat (3) @(negedge CLK);

        chk("pulse_overlap", n_overlap, 0);
        chk("pulse_width", n_wide, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
